// File: rtl/fetch_if.sv
// fetch_if: redirect/stall controls, instruction-memory port and presented bundle of the fetch unit.
interface fetch_if;
  logic        has_mispredict;
  logic [15:0] mispredict_pc;
  logic        jump_for_pcsel;
  logic [15:0] jump_addr_pc;
  logic        stall_for_jump;
  logic        stall_backend;
  logic [15:0] imem_addr;
  logic        imem_en;
  logic [15:0] imem_rdata0;
  logic [15:0] imem_rdata1;
  logic [15:0] imem_rdata2;
  logic [15:0] imem_rdata3;
  logic [15:0] pc;
  logic [15:0] instruction0;
  logic [15:0] instruction1;
  logic [15:0] instruction2;
  logic [15:0] instruction3;
  logic        bundle_valid;
  modport master (
    input  has_mispredict, mispredict_pc, jump_for_pcsel, jump_addr_pc,
           stall_for_jump, stall_backend,
           imem_rdata0, imem_rdata1, imem_rdata2, imem_rdata3,
    output imem_addr, imem_en, pc, instruction0, instruction1, instruction2,
           instruction3, bundle_valid
  );
  modport slave (
    output has_mispredict, mispredict_pc, jump_for_pcsel, jump_addr_pc,
           stall_for_jump, stall_backend,
           imem_rdata0, imem_rdata1, imem_rdata2, imem_rdata3,
    input  imem_addr, imem_en, pc, instruction0, instruction1, instruction2,
           instruction3, bundle_valid
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: 4-wide instruction fetch with one-cycle memory latency, 1-entry skid buffer and redirect squash.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP      = 16'h0000
) (
  input logic clk,
  input logic rst,
  fetch_if.master f
);
  typedef enum logic {RUN, HOLD} state_e;
  state_e state_q;
  logic [15:0] fetch_pc_q, inflight_pc_q, skid_pc_q, pc_q, target;
  logic inflight_valid_q, skid_valid_q, bundle_valid_q, redirect, stall;
  logic [3:0][15:0] skid_data_q, instr_q, rdata;
  assign rdata    = {f.imem_rdata3, f.imem_rdata2, f.imem_rdata1, f.imem_rdata0};
  assign redirect = f.has_mispredict | f.jump_for_pcsel;
  assign stall    = f.stall_for_jump | f.stall_backend;
  assign target   = f.has_mispredict ? f.mispredict_pc : f.jump_addr_pc;
  // The release cycle out of HOLD is a normal sequential cycle, so it issues too.
  assign f.imem_en      = !rst && !redirect && (state_q == RUN || !stall);
  assign f.imem_addr    = fetch_pc_q;
  assign f.pc           = pc_q;
  assign f.bundle_valid = bundle_valid_q;
  assign f.instruction0 = instr_q[0];
  assign f.instruction1 = instr_q[1];
  assign f.instruction2 = instr_q[2];
  assign f.instruction3 = instr_q[3];
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= RUN;
      fetch_pc_q       <= RESET_PC;
      inflight_valid_q <= 1'b0;
      inflight_pc_q    <= '0;
      skid_valid_q     <= 1'b0;
      skid_pc_q        <= '0;
      skid_data_q      <= '0;
      bundle_valid_q   <= 1'b0;
      pc_q             <= '0;
      instr_q          <= {4{NOP}};
    end else if (redirect) begin
      state_q          <= RUN;
      fetch_pc_q       <= target;
      inflight_valid_q <= 1'b0;
      skid_valid_q     <= 1'b0;
      bundle_valid_q   <= 1'b0;
      instr_q          <= {4{NOP}};
    end else if (stall) begin
      state_q          <= HOLD;
      inflight_valid_q <= 1'b0;
      if (inflight_valid_q) begin
        skid_valid_q <= 1'b1;
        skid_pc_q    <= inflight_pc_q;
        skid_data_q  <= rdata;
      end
    end else begin
      state_q          <= RUN;
      fetch_pc_q       <= fetch_pc_q + 16'd4;
      inflight_valid_q <= 1'b1;
      inflight_pc_q    <= fetch_pc_q;
      if (skid_valid_q) begin
        skid_valid_q   <= 1'b0;
        bundle_valid_q <= 1'b1;
        pc_q           <= skid_pc_q;
        instr_q        <= skid_data_q;
      end else if (inflight_valid_q) begin
        bundle_valid_q <= 1'b1;
        pc_q           <= inflight_pc_q;
        instr_q        <= rdata;
      end else begin
        bundle_valid_q <= 1'b0;
        instr_q        <= {4{NOP}};
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus randomized redirect/stall traffic against a bundle-count reference model.
module tb_fetch_unit;
  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam logic [15:0] NOP      = 16'h0000;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  fetch_if f();
  fetch_unit #(.RESET_PC(RESET_PC), .NOP(NOP)) dut (.clk(clk), .rst(rst), .f(f));
  int n_cmp = 0;
  int n_fail = 0;
  // Model: since the last redirect/reset to m_t, m_k sequential cycles have elapsed;
  // the fetch address is m_t+4k and the presented bundle is m_t+4(k-2) once k>=2.
  logic [15:0] m_t, m_pc;
  int m_k;
  logic m_bv, m_held;
  logic [15:0] p_addr;
  logic p_en;
  function automatic logic [63:0] bundle_of(input logic [15:0] a);
    return {a + 16'd3, a + 16'd2, a + 16'd1, a};
  endfunction
  function automatic logic [63:0] shown();
    return {f.instruction3, f.instruction2, f.instruction1, f.instruction0};
  endfunction
  task automatic step();
    logic redir, stl;
    #1;
    p_en  = f.imem_en;
    p_addr = f.imem_addr;
    redir = f.has_mispredict | f.jump_for_pcsel;
    stl   = f.stall_for_jump | f.stall_backend;
    @(posedge clk);
    if (rst) begin
      m_t = RESET_PC; m_k = 0; m_bv = 1'b0; m_pc = 16'h0000; m_held = 1'b0;
    end else if (redir) begin
      m_t = f.has_mispredict ? f.mispredict_pc : f.jump_addr_pc;
      m_k = 0; m_bv = 1'b0; m_held = 1'b0;
    end else if (stl) begin
      m_held = 1'b1;
    end else begin
      m_held = 1'b0;
      m_k++;
      m_bv = (m_k >= 2);
      if (m_bv) m_pc = m_t + 16'(4 * (m_k - 2));
    end
    #1;
    {f.imem_rdata3, f.imem_rdata2, f.imem_rdata1, f.imem_rdata0} =
      p_en ? bundle_of(p_addr) : {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
  endtask
  always @(negedge clk) begin
    if (!rst && (f.stall_for_jump | f.stall_backend) && !(f.has_mispredict | f.jump_for_pcsel)) begin
      n_cmp++;
      if (dut.skid_valid_q && dut.inflight_valid_q) begin
        n_fail++;
        $display("FAIL skid_overflow: write into full skid buffer at %0t", $time);
      end
    end
  end
  task automatic test_reset();
    f.has_mispredict = 0; f.mispredict_pc = 0; f.jump_for_pcsel = 0; f.jump_addr_pc = 0;
    f.stall_for_jump = 0; f.stall_backend = 0;
    {f.imem_rdata3, f.imem_rdata2, f.imem_rdata1, f.imem_rdata0} = '0;
    rst = 1;
    step();
    step();
    #1;
    n_cmp++; if (f.imem_en !== 1'b0) begin n_fail++; $display("FAIL reset_en: got %b want 0", f.imem_en); end
    rst = 0;
    #1;
    n_cmp++; if (f.bundle_valid !== 1'b0) begin n_fail++; $display("FAIL reset_bv: got %b want 0", f.bundle_valid); end
    n_cmp++; if (f.pc !== 16'h0000) begin n_fail++; $display("FAIL reset_pc: got %h want 0000", f.pc); end
    n_cmp++; if (shown() !== {4{NOP}}) begin n_fail++; $display("FAIL reset_instr: got %h want %h", shown(), {4{NOP}}); end
    n_cmp++; if (f.imem_en !== 1'b1) begin n_fail++; $display("FAIL first_en: got %b want 1", f.imem_en); end
    n_cmp++; if (f.imem_addr !== RESET_PC) begin n_fail++; $display("FAIL first_addr: got %h want %h", f.imem_addr, RESET_PC); end
  endtask
  task automatic test_free_run();
    step();
    step();
    n_cmp++; if (f.bundle_valid !== 1'b1 || f.pc !== 16'h0000) begin n_fail++; $display("FAIL run_pc0: got %b/%h want 1/0000", f.bundle_valid, f.pc); end
    n_cmp++; if (shown() !== {16'd3, 16'd2, 16'd1, 16'd0}) begin n_fail++; $display("FAIL run_instr0: got %h want 0003000200010000", shown()); end
    step();
    n_cmp++; if (f.bundle_valid !== 1'b1 || f.pc !== 16'h0004) begin n_fail++; $display("FAIL run_pc4: got %b/%h want 1/0004", f.bundle_valid, f.pc); end
    step();
    n_cmp++; if (f.bundle_valid !== 1'b1 || f.pc !== 16'h0008) begin n_fail++; $display("FAIL run_pc8: got %b/%h want 1/0008", f.bundle_valid, f.pc); end
  endtask
  task automatic test_stall();
    f.stall_backend = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (f.bundle_valid !== 1'b1 || f.pc !== 16'h0008) begin n_fail++; $display("FAIL stall_hold%0d: got %b/%h want 1/0008", i, f.bundle_valid, f.pc); end
    end
    #1;
    n_cmp++; if (f.imem_en !== 1'b0) begin n_fail++; $display("FAIL hold_en: got %b want 0", f.imem_en); end
    f.stall_backend = 0;
    step();
    n_cmp++; if (f.bundle_valid !== 1'b1 || f.pc !== 16'h000c || shown() !== bundle_of(16'h000c)) begin n_fail++; $display("FAIL release_pc12: got %b/%h/%h want 1/000c", f.bundle_valid, f.pc, shown()); end
    step();
    n_cmp++; if (f.bundle_valid !== 1'b1 || f.pc !== 16'h0010) begin n_fail++; $display("FAIL release_pc16: got %b/%h want 1/0010", f.bundle_valid, f.pc); end
  endtask
  task automatic test_jump();
    f.jump_for_pcsel = 1; f.jump_addr_pc = 16'h0040;
    #1;
    n_cmp++; if (f.imem_en !== 1'b0) begin n_fail++; $display("FAIL jump_en: got %b want 0", f.imem_en); end
    step();
    f.jump_for_pcsel = 0;
    n_cmp++; if (f.bundle_valid !== 1'b0 || shown() !== {4{NOP}}) begin n_fail++; $display("FAIL jump_gap1: got %b/%h want 0/nop", f.bundle_valid, shown()); end
    step();
    n_cmp++; if (f.bundle_valid !== 1'b0) begin n_fail++; $display("FAIL jump_gap2: got %b want 0", f.bundle_valid); end
    step();
    n_cmp++; if (f.bundle_valid !== 1'b1 || f.pc !== 16'h0040 || shown() !== bundle_of(16'h0040)) begin n_fail++; $display("FAIL jump_target: got %b/%h/%h want 1/0040", f.bundle_valid, f.pc, shown()); end
  endtask
  task automatic test_priority();
    f.has_mispredict = 1; f.mispredict_pc = 16'h0100;
    f.jump_for_pcsel = 1; f.jump_addr_pc = 16'h0040; f.stall_for_jump = 1;
    step();
    f.has_mispredict = 0; f.jump_for_pcsel = 0; f.stall_for_jump = 0;
    n_cmp++; if (f.bundle_valid !== 1'b0) begin n_fail++; $display("FAIL prio_gap1: got %b want 0", f.bundle_valid); end
    #1;
    n_cmp++; if (f.imem_addr !== 16'h0100 || f.imem_en !== 1'b1) begin n_fail++; $display("FAIL prio_issue: got %h/%b want 0100/1", f.imem_addr, f.imem_en); end
    step();
    n_cmp++; if (f.bundle_valid !== 1'b0) begin n_fail++; $display("FAIL prio_gap2: got %b want 0", f.bundle_valid); end
    step();
    n_cmp++; if (f.bundle_valid !== 1'b1 || f.pc !== 16'h0100) begin n_fail++; $display("FAIL prio_target: got %b/%h want 1/0100", f.bundle_valid, f.pc); end
  endtask
  task automatic test_wrap();
    f.has_mispredict = 1; f.mispredict_pc = 16'hfff8;
    step();
    f.has_mispredict = 0;
    #1;
    n_cmp++; if (f.imem_addr !== 16'hfff8) begin n_fail++; $display("FAIL wrap_a0: got %h want fff8", f.imem_addr); end
    step();
    #1;
    n_cmp++; if (f.imem_addr !== 16'hfffc) begin n_fail++; $display("FAIL wrap_a1: got %h want fffc", f.imem_addr); end
    step();
    #1;
    n_cmp++; if (f.imem_addr !== 16'h0000 || f.imem_en !== 1'b1) begin n_fail++; $display("FAIL wrap_a2: got %h/%b want 0000/1", f.imem_addr, f.imem_en); end
    step();
    step();
    n_cmp++; if (f.bundle_valid !== 1'b1 || f.pc !== 16'h0000 || shown() !== bundle_of(16'h0000)) begin n_fail++; $display("FAIL wrap_bundle: got %b/%h/%h want 1/0000", f.bundle_valid, f.pc, shown()); end
  endtask
  task automatic test_reset_in_hold();
    f.stall_backend = 1;
    step();
    step();
    rst = 1;
    step();
    rst = 0; f.stall_backend = 0;
    n_cmp++; if (f.bundle_valid !== 1'b0 || f.pc !== 16'h0000) begin n_fail++; $display("FAIL rsthold_clear: got %b/%h want 0/0000", f.bundle_valid, f.pc); end
    step();
    n_cmp++; if (f.bundle_valid !== 1'b0) begin n_fail++; $display("FAIL rsthold_noskid: got %b/%h want 0", f.bundle_valid, f.pc); end
    step();
    n_cmp++; if (f.bundle_valid !== 1'b1 || f.pc !== RESET_PC) begin n_fail++; $display("FAIL rsthold_restart: got %b/%h want 1/%h", f.bundle_valid, f.pc, RESET_PC); end
  endtask
  task automatic test_random();
    logic redir, stl, en_exp;
    for (int c = 0; c < 800; c++) begin
      rst              = ($urandom_range(0, 79) == 0);
      f.has_mispredict = ($urandom_range(0, 15) == 0);
      f.jump_for_pcsel = ($urandom_range(0, 11) == 0);
      f.stall_for_jump = ($urandom_range(0, 9) == 0);
      f.stall_backend  = ($urandom_range(0, 3) == 0);
      f.mispredict_pc  = 16'($urandom);
      f.jump_addr_pc   = 16'($urandom);
      #1;
      redir  = f.has_mispredict | f.jump_for_pcsel;
      stl    = f.stall_for_jump | f.stall_backend;
      en_exp = !rst && !redir && !(m_held && stl);
      n_cmp++; if (f.bundle_valid !== m_bv) begin n_fail++; $display("FAIL rnd_bv c%0d: got %b want %b", c, f.bundle_valid, m_bv); end
      n_cmp++; if (f.pc !== m_pc) begin n_fail++; $display("FAIL rnd_pc c%0d: got %h want %h", c, f.pc, m_pc); end
      n_cmp++; if (shown() !== (m_bv ? bundle_of(m_pc) : {4{NOP}})) begin n_fail++; $display("FAIL rnd_instr c%0d: got %h want %h", c, shown(), m_bv ? bundle_of(m_pc) : {4{NOP}}); end
      n_cmp++; if (f.imem_en !== en_exp) begin n_fail++; $display("FAIL rnd_en c%0d: got %b want %b", c, f.imem_en, en_exp); end
      n_cmp++; if (f.imem_addr !== m_t + 16'(4 * m_k)) begin n_fail++; $display("FAIL rnd_addr c%0d: got %h want %h", c, f.imem_addr, m_t + 16'(4 * m_k)); end
      step();
    end
    rst = 0; f.has_mispredict = 0; f.jump_for_pcsel = 0; f.stall_for_jump = 0; f.stall_backend = 0;
  endtask
  initial begin
    test_reset();
    test_free_run();
    test_stall();
    test_jump();
    test_priority();
    test_wrap();
    test_reset_in_hold();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
